switch_debouncer: RTL and testbench

- Conditions raw board switch and button inputs into clean, glitch-free levels.
- Its outputs drive the combinational gate stage inputs (the NAND inputs a, b) during lab exercises.
- Per channel: a synchronizer, a consecutive-cycle stability counter and a 4-state FSM.
- Channels are independent and identical.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_channel.sv | 125 ++++++++++++
 rtl/switch_debouncer.sv | 32 +++
 tb/tb_switch_debouncer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
// The optional edge pulses are controlled by SWITCH_DEBOUNCER_EDGE_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_e;

    localparam int DEF_CNT_MAX     = 1000000;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchronizer, stability counter and 4-state FSM.
// Registered rise/fall pulses exist only when SWITCH_DEBOUNCER_EDGE_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_MAX     = DEF_CNT_MAX,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic sw_out,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    // With CNT_MAX=1 the WAIT state must be left on the very next edge, so entry starts at 0.
    localparam logic [CW-1:0] CNT_ENTRY = (CNT_MAX > 1) ? CW'(1) : '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   out_q;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic rise_q;
    logic fall_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
`endif
        end else begin
`ifdef SWITCH_DEBOUNCER_EDGE_EN
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`endif
            case (state_q)
                S_LOW: begin
                    if (sync) begin
                        state_q <= S_WAIT_HIGH;
                        cnt_q   <= CNT_ENTRY;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!sync) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                        out_q   <= 1'b1;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
                        rise_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                S_HIGH: begin
                    if (!sync) begin
                        state_q <= S_WAIT_LOW;
                        cnt_q   <= CNT_ENTRY;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_WAIT_LOW: begin
                    if (sync) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                        out_q   <= 1'b0;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
                        fall_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= S_LOW;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sw_out = out_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH independent debounce channels for raw switch/button inputs.
// Define SWITCH_DEBOUNCER_EDGE_EN to get registered rise/fall pulses.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int CNT_MAX     = DEF_CNT_MAX,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : gen_ch
        debounce_channel #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_channel (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_in  (sw_in[i]),
            .sw_out (sw_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (WIDTH=2, CNT_MAX=4, SYNC_STAGES=2).
// Reference model: an output flips once the delayed input has disagreed with it for CNT_MAX edges in a row.
module tb_switch_debouncer;

    localparam int WIDTH   = 2;
    localparam int CNT_MAX = 4;
    localparam int SYNC    = 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
    } exp_t;

    exp_t             expQ[$];
    logic [WIDTH-1:0] delayLine[SYNC];
    logic [WIDTH-1:0] modelOut;
    int               runLen[WIDTH];
    int               errors = 0;
    int               checks = 0;

    switch_debouncer #(
        .WIDTH       (WIDTH),
        .CNT_MAX     (CNT_MAX),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .rise   (rise),
        .fall   (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Advance the reference model by one rising edge and queue what the outputs must show afterwards.
    task automatic modelEdge();
        exp_t e;
        e.out  = '0;
        e.rise = '0;
        e.fall = '0;
        if (!rst_n) begin
            for (int s = 0; s < SYNC; s++) delayLine[s] = '0;
            modelOut = '0;
            for (int c = 0; c < WIDTH; c++) runLen[c] = 0;
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                if (delayLine[SYNC-1][c] != modelOut[c]) runLen[c]++;
                else runLen[c] = 0;
                if (runLen[c] == CNT_MAX) begin
                    modelOut[c] = ~modelOut[c];
                    runLen[c]   = 0;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
                    if (modelOut[c]) e.rise[c] = 1'b1;
                    else e.fall[c] = 1'b1;
`endif
                end
            end
            for (int s = SYNC - 1; s > 0; s--) delayLine[s] = delayLine[s-1];
            delayLine[0] = sw_in;
        end
        e.out = modelOut;
        expQ.push_back(e);
    endtask

    // Drive new levels mid low-phase, then let the model follow the next rising edge.
    task automatic applyStimulus(input logic rstnVal, input logic [WIDTH-1:0] inVal, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            #2;
            sw_in = inVal;
            if (rst_n && !rstnVal) begin
                rst_n = 1'b0;
                #1;
                checkOutput("asyncResetOut", sw_out, '0);
            end else begin
                rst_n = rstnVal;
            end
            @(posedge clk);
            modelEdge();
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("sw_out", sw_out, e.out);
            checkOutput("rise", rise, e.rise);
            checkOutput("fall", fall, e.fall);
        end
    end

    initial begin
        rst_n = 1'b0;
        sw_in = '0;
        for (int s = 0; s < SYNC; s++) delayLine[s] = '0;
        modelOut = '0;
        for (int c = 0; c < WIDTH; c++) runLen[c] = 0;

        $display("[TB] reset release with inputs high");
        applyStimulus(1'b0, 2'b11, 3);
        applyStimulus(1'b1, 2'b11, 10);
        applyStimulus(1'b1, 2'b00, 10);

        $display("[TB] clean press on ch0");
        applyStimulus(1'b1, 2'b01, 10);
        applyStimulus(1'b1, 2'b00, 10);

        $display("[TB] bouncing press on ch0");
        applyStimulus(1'b1, 2'b01, 1);
        applyStimulus(1'b1, 2'b00, 1);
        applyStimulus(1'b1, 2'b01, 1);
        applyStimulus(1'b1, 2'b00, 1);
        applyStimulus(1'b1, 2'b01, 10);

        $display("[TB] glitch on ch1");
        applyStimulus(1'b1, 2'b11, 3);
        applyStimulus(1'b1, 2'b01, 10);

        $display("[TB] reset in the middle of a count");
        applyStimulus(1'b1, 2'b00, 10);
        applyStimulus(1'b1, 2'b11, 4);
        applyStimulus(1'b0, 2'b11, 2);
        applyStimulus(1'b1, 2'b11, 10);

        $display("[TB] simultaneous release and press");
        applyStimulus(1'b1, 2'b01, 10);
        applyStimulus(1'b1, 2'b10, 10);

        $display("[TB] random bouncing");
        for (int n = 0; n < 300; n++) begin
            logic [WIDTH-1:0] v;
            v = WIDTH'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) applyStimulus(1'b0, v, $urandom_range(1, 3));
            else applyStimulus(1'b1, v, $urandom_range(1, 7));
        end

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
